// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period (rising edge to rising edge) of
// an asynchronous PWM input. Each result is handed out through a one-entry
// valid/ready register. A constant input and saturating counts are reported.
`timescale 1ns/1ps
module pwm_capture #(
    parameter int W           = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwm_in,
    input  logic         en,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_high,
    output logic [W-1:0] m_period,
    output logic         m_sat,
    output logic         m_stuck,
    output logic         m_level,
    output logic         dropped
);

    localparam logic [1:0]   ST_IDLE   = 2'd0;
    localparam logic [1:0]   ST_ARM    = 2'd1;
    localparam logic [1:0]   ST_MEAS   = 2'd2;
    localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO  = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE   = W'(1);
    localparam logic [W-1:0] TIMEOUT_V = W'(TIMEOUT);

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        if (v == CNT_MAX) begin
            r = CNT_MAX;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic [1:0]             state_r;
    logic [W-1:0]           per_r;
    logic [W-1:0]           hi_r;
    logic                   sat_r;
    logic [W-1:0]           idle_r;
    logic                   armoff_r;

    logic                   s_s;
    logic                   rise_s;
    logic                   change_s;
    logic                   stuck_hit_s;
    logic [1:0]             state_nx_s;
    logic [W-1:0]           per_nx_s;
    logic [W-1:0]           hi_nx_s;
    logic                   sat_nx_s;
    logic [W-1:0]           idle_nx_s;
    logic                   armoff_nx_s;
    logic                   emit_s;
    logic [W-1:0]           e_high_s;
    logic [W-1:0]           e_period_s;
    logic                   e_sat_s;
    logic                   e_stuck_s;
    logic                   e_level_s;
    logic                   load_s;
    logic                   drop_s;

    assign s_s      = sync_r[SYNC_STAGES-1];
    assign rise_s   = s_s & ~s_d_r;
    assign change_s = s_s ^ s_d_r;
    // A stuck report fires once idle time hits the limit; a change of s in the
    // same cycle wins, so a rise is never lost to a stuck report.
    assign stuck_hit_s = (idle_r == TIMEOUT_V) && !armoff_r && !change_s;

    // Synchronizer chain for pwm_in plus the one-cycle delayed copy for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
            s_d_r  <= s_s;
        end
    end

    // Next-state, counter update and result formation.
    always_comb begin
        state_nx_s  = state_r;
        per_nx_s    = per_r;
        hi_nx_s     = hi_r;
        sat_nx_s    = sat_r;
        idle_nx_s   = idle_r;
        armoff_nx_s = armoff_r;
        emit_s      = 1'b0;
        e_high_s    = CNT_ZERO;
        e_period_s  = CNT_ZERO;
        e_sat_s     = 1'b0;
        e_stuck_s   = 1'b0;
        e_level_s   = 1'b0;
        if (!en || (state_r == ST_IDLE) || (state_r > ST_MEAS)) begin
            // Disabled, idle or corrupted state: clear everything, arm when enabled.
            state_nx_s  = en ? ST_ARM : ST_IDLE;
            per_nx_s    = CNT_ZERO;
            hi_nx_s     = CNT_ZERO;
            sat_nx_s    = 1'b0;
            idle_nx_s   = CNT_ZERO;
            armoff_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_ARM: begin
                    if (rise_s) begin
                        state_nx_s = ST_MEAS;
                        per_nx_s   = CNT_ONE;
                        hi_nx_s    = CNT_ONE;
                        sat_nx_s   = 1'b0;
                    end else begin
                        state_nx_s = ST_ARM;
                    end
                end
                ST_MEAS: begin
                    if (rise_s) begin
                        // The rise sample already belongs to the next period.
                        emit_s     = 1'b1;
                        e_high_s   = hi_r;
                        e_period_s = per_r;
                        e_sat_s    = sat_r;
                        per_nx_s   = CNT_ONE;
                        hi_nx_s    = CNT_ONE;
                        sat_nx_s   = 1'b0;
                    end else if (stuck_hit_s) begin
                        state_nx_s = ST_ARM;
                        per_nx_s   = CNT_ZERO;
                        hi_nx_s    = CNT_ZERO;
                        sat_nx_s   = 1'b0;
                    end else begin
                        per_nx_s = sat_inc(per_r);
                        hi_nx_s  = s_s ? sat_inc(hi_r) : hi_r;
                        sat_nx_s = sat_r | (sat_inc(per_r) == CNT_MAX);
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
            if (stuck_hit_s) begin
                emit_s      = 1'b1;
                e_high_s    = s_s ? CNT_MAX : CNT_ZERO;
                e_stuck_s   = 1'b1;
                e_level_s   = s_s;
                armoff_nx_s = 1'b1;
            end else begin
                armoff_nx_s = change_s ? 1'b0 : armoff_r;
            end
            if (change_s) begin
                idle_nx_s = CNT_ZERO;
            end else if (idle_r != TIMEOUT_V) begin
                idle_nx_s = idle_r + CNT_ONE;
            end else begin
                idle_nx_s = idle_r;
            end
        end
    end

    assign load_s = emit_s && (!m_valid || m_ready);
    assign drop_s = emit_s && m_valid && !m_ready;

    // Measurement state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            per_r    <= CNT_ZERO;
            hi_r     <= CNT_ZERO;
            sat_r    <= 1'b0;
            idle_r   <= CNT_ZERO;
            armoff_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            per_r    <= per_nx_s;
            hi_r     <= hi_nx_s;
            sat_r    <= sat_nx_s;
            idle_r   <= idle_nx_s;
            armoff_r <= armoff_nx_s;
        end
    end

    // One-entry output register; fields only change on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_high   <= CNT_ZERO;
            m_period <= CNT_ZERO;
            m_sat    <= 1'b0;
            m_stuck  <= 1'b0;
            m_level  <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            dropped <= drop_s;
            if (load_s) begin
                m_valid  <= 1'b1;
                m_high   <= e_high_s;
                m_period <= e_period_s;
                m_sat    <= e_sat_s;
                m_stuck  <= e_stuck_s;
                m_level  <= e_level_s;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end else begin
                m_valid <= m_valid;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: three instances (W=16 default, W=8 for
// saturation, W=8 with short timeout for stuck reports) share one stimulus.
`timescale 1ns/1ps
module tb_pwm_capture;

    logic clk, rst_n, pwm_in, en, m_ready;
    logic a_valid, a_sat, a_stuck, a_level, a_dropped;
    logic [15:0] a_high, a_period;
    logic b_valid, b_sat, b_stuck, b_level, b_dropped;
    logic [7:0] b_high, b_period;
    logic c_valid, c_sat, c_stuck, c_level, c_dropped;
    logic [7:0] c_high, c_period;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_num = 0;
    int rise_cyc = 0;
    int drop_cnt = 0;
    int hi_len = 3;
    int per_len = 10;
    bit pwm_run = 1'b0;
    logic pwm_level = 1'b0;
    int sel = 0;

    logic cv, cs, ck, cl, cd;
    logic [15:0] ch, cp;

    pwm_capture #(.W(16), .SYNC_STAGES(2), .TIMEOUT(1000)) dut_a (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .en(en),
        .m_valid(a_valid), .m_ready(m_ready), .m_high(a_high), .m_period(a_period),
        .m_sat(a_sat), .m_stuck(a_stuck), .m_level(a_level), .dropped(a_dropped));

    pwm_capture #(.W(8), .SYNC_STAGES(2), .TIMEOUT(250)) dut_b (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .en(en),
        .m_valid(b_valid), .m_ready(m_ready), .m_high(b_high), .m_period(b_period),
        .m_sat(b_sat), .m_stuck(b_stuck), .m_level(b_level), .dropped(b_dropped));

    pwm_capture #(.W(8), .SYNC_STAGES(2), .TIMEOUT(20)) dut_c (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .en(en),
        .m_valid(c_valid), .m_ready(m_ready), .m_high(c_high), .m_period(c_period),
        .m_sat(c_sat), .m_stuck(c_stuck), .m_level(c_level), .dropped(c_dropped));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Select which instance the checking tasks observe.
    always_comb begin
        case (sel)
            0: begin
                cv = a_valid; ch = a_high; cp = a_period;
                cs = a_sat; ck = a_stuck; cl = a_level; cd = a_dropped;
            end
            1: begin
                cv = b_valid; ch = {8'd0, b_high}; cp = {8'd0, b_period};
                cs = b_sat; ck = b_stuck; cl = b_level; cd = b_dropped;
            end
            default: begin
                cv = c_valid; ch = {8'd0, c_high}; cp = {8'd0, c_period};
                cs = c_sat; ck = c_stuck; cl = c_level; cd = c_dropped;
            end
        endcase
    end

    // Count dropped pulses of the observed instance.
    always @(negedge clk) if (cd === 1'b1) drop_cnt <= drop_cnt + 1;

    // PWM generator: new high/period lengths take effect at a period start.
    initial begin
        int ph, cur_hi, cur_per;
        logic nv;
        pwm_in = 1'b0;
        ph = 0; cur_hi = 3; cur_per = 10;
        forever begin
            @(negedge clk);
            if (pwm_run) begin
                if (ph == 0) begin
                    cur_hi = hi_len;
                    cur_per = per_len;
                end
                nv = (ph < cur_hi);
                if (nv && !pwm_in) begin
                    rise_num = rise_num + 1;
                    rise_cyc = cyc;
                end
                pwm_in = nv;
                ph = (ph + 1 >= cur_per) ? 0 : ph + 1;
            end else begin
                pwm_in = pwm_level;
                ph = 0;
            end
        end
    end

    task automatic do_reset;
        en = 1'b0; pwm_run = 1'b0; pwm_level = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Wait (bounded) for a handshake on the observed instance and capture it.
    task automatic get_result(output logic [15:0] h, output logic [15:0] p,
                              output logic sa, output logic st, output logic lv,
                              output int lat, output int rn, output bit got);
        got = 1'b0; h = 16'd0; p = 16'd0; sa = 1'b0; st = 1'b0; lv = 1'b0;
        lat = 0; rn = 0;
        for (int i = 0; i < 1500; i++) begin
            if (cv === 1'b1 && m_ready === 1'b1) begin
                got = 1'b1;
                h = ch; p = cp; sa = cs; st = ck; lv = cl;
                lat = cyc - rise_cyc;
                rn = rise_num;
                break;
            end
            @(negedge clk);
        end
        if (got) @(negedge clk);
    endtask

    task automatic test_reset;
        bit seen;
        sel = 0; pwm_run = 1'b0; pwm_level = 1'b0; en = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (a_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%0b expected=0", a_valid);
        end
        checks++;
        if ({a_high, a_period} !== 32'd0) begin
            failures++; $display("FAIL reset_fields got high=%0d period=%0d expected 0 0", a_high, a_period);
        end
        checks++;
        if ({a_sat, a_stuck, a_level, a_dropped} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b expected=0000", {a_sat, a_stuck, a_level, a_dropped});
        end
        rst_n = 1'b1;
        pwm_run = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL disabled_no_result got valid while en=0 expected none");
        end
    endtask

    task automatic test_basic;
        logic [15:0] h, p; logic sa, st, lv; int lat, rn, base; bit got;
        do_reset;
        sel = 0; hi_len = 3; per_len = 10; m_ready = 1'b1; base = drop_cnt;
        en = 1'b1; pwm_run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            get_result(h, p, sa, st, lv, lat, rn, got);
            checks++;
            if (!got || h !== 16'd3 || p !== 16'd10 || sa !== 1'b0 || st !== 1'b0 || lv !== 1'b0) begin
                failures++;
                $display("FAIL basic_result got=%0b hi=%0d per=%0d sat=%0b stuck=%0b lvl=%0b expected hi=3 per=10 flags=0",
                         got, h, p, sa, st, lv);
            end
            if (k == 0) begin
                checks++;
                if (lat != 3) begin
                    failures++; $display("FAIL basic_latency got=%0d expected=3", lat);
                end
            end
        end
        checks++;
        if (drop_cnt - base != 0) begin
            failures++; $display("FAIL basic_no_drop got=%0d expected=0", drop_cnt - base);
        end
    endtask

    task automatic test_duty_change;
        logic [15:0] h, p; logic sa, st, lv; int lat, rn; bit got;
        hi_len = 8;
        get_result(h, p, sa, st, lv, lat, rn, got);
        checks++;
        if (!got || h !== 16'd3 || p !== 16'd10) begin
            failures++; $display("FAIL duty_old got=%0b hi=%0d per=%0d expected hi=3 per=10", got, h, p);
        end
        for (int k = 0; k < 3; k++) begin
            get_result(h, p, sa, st, lv, lat, rn, got);
            checks++;
            if (!got || h !== 16'd8 || p !== 16'd10 || sa !== 1'b0) begin
                failures++; $display("FAIL duty_new got=%0b hi=%0d per=%0d sat=%0b expected hi=8 per=10 sat=0", got, h, p, sa);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] h, p; logic sa, st, lv; int lat, rn, base; bit got, seen, bad;
        get_result(h, p, sa, st, lv, lat, rn, got);
        m_ready = 1'b0; base = drop_cnt; seen = 1'b0; bad = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (a_valid === 1'b1) begin
                seen = 1'b1;
                if (a_high !== 16'd8 || a_period !== 16'd10) bad = 1'b1;
            end else if (seen) begin
                bad = 1'b1;
            end
        end
        checks++;
        if (!seen || bad) begin
            failures++; $display("FAIL hold_stable got seen=%0b bad=%0b expected seen=1 bad=0", seen, bad);
        end
        checks++;
        if (drop_cnt - base != 1) begin
            failures++; $display("FAIL hold_drops got=%0d expected=1", drop_cnt - base);
        end
        m_ready = 1'b1;
        get_result(h, p, sa, st, lv, lat, rn, got);
        checks++;
        if (!got || h !== 16'd8 || p !== 16'd10) begin
            failures++; $display("FAIL held_accept got=%0b hi=%0d per=%0d expected hi=8 per=10", got, h, p);
        end
        get_result(h, p, sa, st, lv, lat, rn, got);
        checks++;
        if (!got || h !== 16'd8 || p !== 16'd10 || lat != 3) begin
            failures++; $display("FAIL fresh_after_hold got=%0b hi=%0d per=%0d lat=%0d expected hi=8 per=10 lat=3", got, h, p, lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] h, p; logic sa, st, lv; int lat, rn, rn0; bit got;
        hi_len = 3;
        get_result(h, p, sa, st, lv, lat, rn, got);
        get_result(h, p, sa, st, lv, lat, rn, got);
        m_ready = 1'b0; got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (a_valid === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            failures++; $display("FAIL rst_mid_pending got valid=0 expected=1");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || {a_high, a_period} !== 32'd0) begin
            failures++; $display("FAIL rst_async got valid=%0b hi=%0d per=%0d expected 0 0 0", a_valid, a_high, a_period);
        end
        @(negedge clk);
        m_ready = 1'b1;
        #2 rst_n = 1'b1;
        rn0 = rise_num;
        @(negedge clk);
        get_result(h, p, sa, st, lv, lat, rn, got);
        checks++;
        if (!got || rn - rn0 != 2 || h !== 16'd3 || p !== 16'd10) begin
            failures++; $display("FAIL rst_restart got=%0b edges=%0d hi=%0d per=%0d expected edges=2 hi=3 per=10", got, rn - rn0, h, p);
        end
    endtask

    task automatic test_en_pulse;
        logic [15:0] h, p; logic sa, st, lv; int lat, rn, rn0; bit got;
        m_ready = 1'b0; got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (a_valid === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        rn0 = rise_num;
        checks++;
        if (!got || a_valid !== 1'b1 || a_high !== 16'd3 || a_period !== 16'd10) begin
            failures++; $display("FAIL en_keep_pending got valid=%0b hi=%0d per=%0d expected 1 3 10", a_valid, a_high, a_period);
        end
        m_ready = 1'b1;
        get_result(h, p, sa, st, lv, lat, rn, got);
        get_result(h, p, sa, st, lv, lat, rn, got);
        checks++;
        if (!got || rn - rn0 != 2 || h !== 16'd3 || p !== 16'd10) begin
            failures++; $display("FAIL en_restart got=%0b edges=%0d hi=%0d per=%0d expected edges=2 hi=3 per=10", got, rn - rn0, h, p);
        end
    endtask

    task automatic test_saturation;
        logic [15:0] h, p; logic sa, st, lv; int lat, rn; bit got;
        do_reset;
        sel = 1; hi_len = 100; per_len = 300; m_ready = 1'b1;
        en = 1'b1; pwm_run = 1'b1;
        for (int k = 0; k < 2; k++) begin
            get_result(h, p, sa, st, lv, lat, rn, got);
            checks++;
            if (!got || h !== 16'd100 || p !== 16'd255 || sa !== 1'b1 || st !== 1'b0) begin
                failures++; $display("FAIL sat_result got=%0b hi=%0d per=%0d sat=%0b stuck=%0b expected hi=100 per=255 sat=1 stuck=0",
                                     got, h, p, sa, st);
            end
        end
    endtask

    task automatic test_stuck(input logic lvl);
        logic [15:0] h, p, sh, sp, exp_h; logic sa, st, lv, ss, sl; int lat, rn, nst; bit got;
        do_reset;
        sel = 2; hi_len = 3; per_len = 10; m_ready = 1'b1;
        en = 1'b1; pwm_run = 1'b1;
        exp_h = lvl ? 16'd255 : 16'd0;
        get_result(h, p, sa, st, lv, lat, rn, got);
        checks++;
        if (!got || h !== 16'd3 || p !== 16'd10 || st !== 1'b0) begin
            failures++; $display("FAIL stuck_pre got=%0b hi=%0d per=%0d stuck=%0b expected hi=3 per=10 stuck=0", got, h, p, st);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (pwm_in === lvl) break;
        end
        pwm_level = lvl; pwm_run = 1'b0;
        nst = 0; sh = 16'd0; sp = 16'd0; ss = 1'b0; sl = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (cv === 1'b1 && m_ready === 1'b1 && ck === 1'b1) begin
                nst++; sh = ch; sp = cp; ss = cs; sl = cl;
            end
        end
        checks++;
        if (nst != 1) begin
            failures++; $display("FAIL stuck_count lvl=%0b got=%0d expected=1", lvl, nst);
        end
        checks++;
        if (sh !== exp_h || sp !== 16'd0 || ss !== 1'b0 || sl !== lvl) begin
            failures++; $display("FAIL stuck_fields got hi=%0d per=%0d sat=%0b lvl=%0b expected hi=%0d per=0 sat=0 lvl=%0b",
                                 sh, sp, ss, sl, exp_h, lvl);
        end
        pwm_run = 1'b1;
        get_result(h, p, sa, st, lv, lat, rn, got);
        checks++;
        if (!got || h !== 16'd3 || p !== 16'd10 || st !== 1'b0 || lv !== 1'b0) begin
            failures++; $display("FAIL stuck_resume got=%0b hi=%0d per=%0d stuck=%0b lvl=%0b expected hi=3 per=10 stuck=0 lvl=0",
                                 got, h, p, st, lv);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
        test_reset;
        test_basic;
        test_duty_change;
        test_back_to_back;
        test_reset_mid;
        test_en_pulse;
        test_saturation;
        test_stuck(1'b1);
        test_stuck(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
